// File: rtl/lsu_wb_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_wb_stage_pkg
// Brief    : Shared constants for the load/store + writeback pipeline stage:
//            datapath width, RV64 load/store func3 codes, FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_wb_stage_pkg;

  localparam int XLEN = 64;

  // Load width/sign codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;

  // Store width codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MEM  = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_MEM  = ST_MEM,
    S_WB   = ST_WB
  } lsu_state_e;

  // Byte-enable pattern of an access of size 1/2/4/8 bytes, lane 0 based
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_wb_stage_if
// Brief    : Bundle of the execute-result handshake, data-memory port and
//            register-file write port seen by the load/store stage.
//            slave  = the load/store stage itself
//            master = its surroundings (execute stage, memory, regfile)
// Revision : 1.0 - initial release
// ============================================================================
interface lsu_wb_stage_if #(
  parameter int XLEN = lsu_wb_stage_pkg::XLEN
);
  // execute-stage result
  logic            exu_valid;
  logic [XLEN-1:0] exu_rd;
  logic [4:0]      exu_rd_addr;
  logic            exu_rd_w;
  logic            exu_is_load;
  logic            exu_is_store;
  logic [2:0]      exu_func3;
  logic [XLEN-1:0] exu_st_data;
  logic            lsu_allowin;
  // data-memory port
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [7:0]      dmem_wmask;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_rdata;
  // writeback / forwarding
  logic            wb_en;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            misalign;

  modport slave (
    input  exu_valid, exu_rd, exu_rd_addr, exu_rd_w, exu_is_load,
           exu_is_store, exu_func3, exu_st_data, dmem_ack, dmem_rdata,
    output lsu_allowin, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           dmem_wmask, wb_en, wb_addr, wb_data, misalign
  );

  modport master (
    output exu_valid, exu_rd, exu_rd_addr, exu_rd_w, exu_is_load,
           exu_is_store, exu_func3, exu_st_data, dmem_ack, dmem_rdata,
    input  lsu_allowin, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           dmem_wmask, wb_en, wb_addr, wb_data, misalign
  );

endinterface
`default_nettype wire

// File: rtl/lsu_wb_stage_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Brief    : Combinational access formatter: store lane shift and byte mask,
//            load lane shift with sign/zero extension, alignment check.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align #(
  parameter int XLEN = 64
) (
  input  wire logic [2:0]      i_func3,
  input  wire logic            i_is_mem,
  input  wire logic [XLEN-1:0] i_addr,
  input  wire logic [XLEN-1:0] i_st_data,
  input  wire logic [XLEN-1:0] i_rdata,
  output logic [XLEN-1:0]      o_dmem_addr,
  output logic [XLEN-1:0]      o_wdata,
  output logic [7:0]           o_wmask,
  output logic [XLEN-1:0]      o_ld_data,
  output logic                 o_misalign
);
  import lsu_wb_stage_pkg::*;

  logic [2:0]      w_off;
  logic [XLEN-1:0] w_shifted;
  logic            w_unaligned;

  assign w_off       = i_addr[2:0];
  assign o_dmem_addr = {i_addr[XLEN-1:3], 3'b000};
  assign o_wmask     = size_mask(i_func3[1:0]) << w_off;
  assign o_wdata     = i_st_data << {w_off, 3'b000};
  assign w_shifted   = i_rdata >> {w_off, 3'b000};

  // Address must be a multiple of the access size; code 111 is never legal
  always_comb begin
    w_unaligned = 1'b0;
    case (i_func3[1:0])
      2'd0:    w_unaligned = 1'b0;
      2'd1:    w_unaligned = w_off[0];
      2'd2:    w_unaligned = |w_off[1:0];
      default: w_unaligned = |w_off;
    endcase
    o_misalign = i_is_mem && (w_unaligned || (i_func3 == F3_BAD));
  end

  // Extend the addressed lane to a full register value
  always_comb begin
    o_ld_data = w_shifted;
    case (i_func3)
      F3_LB:   o_ld_data = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
      F3_LH:   o_ld_data = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      F3_LW:   o_ld_data = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
      F3_LD:   o_ld_data = w_shifted;
      F3_LBU:  o_ld_data = {{(XLEN-8){1'b0}},  w_shifted[7:0]};
      F3_LHU:  o_ld_data = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
      F3_LWU:  o_ld_data = {{(XLEN-32){1'b0}}, w_shifted[31:0]};
      default: o_ld_data = w_shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : lsu_wb_stage
// Brief    : Pipeline stage 4. Accepts one execute result per handshake,
//            performs the load/store on a req/ack memory port and writes the
//            (extended) result to the register file. The writeback port also
//            serves as the execute-stage bypass source.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_wb_stage #(
  parameter int XLEN = lsu_wb_stage_pkg::XLEN
) (
  input wire logic       clk,
  input wire logic       rst_n,
  lsu_wb_stage_if.slave  bus
);
  import lsu_wb_stage_pkg::*;

  lsu_state_e      r_state;
  lsu_state_e      w_state_nxt;

  logic [XLEN-1:0] r_rd;
  logic [4:0]      r_rd_addr;
  logic            r_rd_w;
  logic            r_is_load;
  logic            r_is_store;
  logic [2:0]      r_func3;
  logic [XLEN-1:0] r_st_data;
  logic            r_misalign;
  logic [XLEN-1:0] r_ld_res;

  logic            w_in_mem;
  logic            w_capture;
  logic [2:0]      w_al_func3;
  logic            w_al_mem;
  logic [XLEN-1:0] w_al_addr;
  logic [XLEN-1:0] w_al_st;
  logic [XLEN-1:0] w_dmem_addr;
  logic [XLEN-1:0] w_wdata;
  logic [7:0]      w_wmask;
  logic [XLEN-1:0] w_ld_data;
  logic            w_misalign;

  assign w_in_mem        = (r_state == S_MEM);
  assign bus.lsu_allowin = !w_in_mem;
  assign w_capture       = bus.exu_valid && !w_in_mem;

  // Outside MEM the formatter checks the incoming result for alignment;
  // inside MEM it formats the held access. Capture never happens in MEM,
  // so one formatter serves both.
  assign w_al_func3 = w_in_mem ? r_func3   : bus.exu_func3;
  assign w_al_addr  = w_in_mem ? r_rd      : bus.exu_rd;
  assign w_al_st    = w_in_mem ? r_st_data : bus.exu_st_data;
  assign w_al_mem   = w_in_mem || bus.exu_is_load || bus.exu_is_store;

  lsu_align #(.XLEN(XLEN)) u_align (
    .i_func3     (w_al_func3),
    .i_is_mem    (w_al_mem),
    .i_addr      (w_al_addr),
    .i_st_data   (w_al_st),
    .i_rdata     (bus.dmem_rdata),
    .o_dmem_addr (w_dmem_addr),
    .o_wdata     (w_wdata),
    .o_wmask     (w_wmask),
    .o_ld_data   (w_ld_data),
    .o_misalign  (w_misalign)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and all stage outputs
  always_comb begin
    w_state_nxt    = r_state;
    bus.dmem_req   = 1'b0;
    bus.dmem_we    = 1'b0;
    bus.dmem_addr  = '0;
    bus.dmem_wdata = '0;
    bus.dmem_wmask = '0;
    bus.wb_en      = 1'b0;
    bus.wb_addr    = '0;
    bus.wb_data    = '0;
    bus.misalign   = 1'b0;
    case (r_state)
      S_MEM: begin
        bus.dmem_req   = 1'b1;
        bus.dmem_we    = r_is_store;
        bus.dmem_addr  = w_dmem_addr;
        bus.dmem_wdata = r_is_store ? w_wdata : '0;
        bus.dmem_wmask = r_is_store ? w_wmask : 8'h00;
        if (bus.dmem_ack) w_state_nxt = S_WB;
      end
      S_WB: begin
        bus.wb_en    = r_rd_w && (r_rd_addr != 5'd0) && !r_is_store && !r_misalign;
        bus.wb_addr  = r_rd_addr;
        bus.wb_data  = r_is_load ? r_ld_res : r_rd;
        bus.misalign = r_misalign;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A new result may be taken in IDLE and in the WB cycle
    if (w_capture) w_state_nxt = (w_al_mem && !w_misalign) ? S_MEM : S_WB;
  end

  // Hold the captured instruction; register the load result on ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd       <= '0;
      r_rd_addr  <= '0;
      r_rd_w     <= 1'b0;
      r_is_load  <= 1'b0;
      r_is_store <= 1'b0;
      r_func3    <= '0;
      r_st_data  <= '0;
      r_misalign <= 1'b0;
      r_ld_res   <= '0;
    end else begin
      if (w_capture) begin
        r_rd       <= bus.exu_rd;
        r_rd_addr  <= bus.exu_rd_addr;
        r_rd_w     <= bus.exu_rd_w;
        r_is_load  <= bus.exu_is_load;
        r_is_store <= bus.exu_is_store;
        r_func3    <= bus.exu_func3;
        r_st_data  <= bus.exu_st_data;
        r_misalign <= w_misalign;
      end
      if (w_in_mem && bus.dmem_ack) r_ld_res <= w_ld_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_wb_stage
// Brief    : Self-checking bench for lsu_wb_stage. Each issued instruction is
//            turned into a per-cycle expectation timeline by a reference model
//            written from the architectural rules; a monitor compares every
//            cycle on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_wb_stage;

  localparam int NC = 8192;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_err;
  int   n_chk;
  bit   chk_on;

  lsu_wb_stage_if #(.XLEN(64)) bus ();

  lsu_wb_stage #(.XLEN(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // expectation timeline, indexed by cycle number
  bit          e_allow [0:NC-1];
  bit          e_req   [0:NC-1];
  bit          e_we    [0:NC-1];
  logic [63:0] e_addr  [0:NC-1];
  logic [63:0] e_wdata [0:NC-1];
  logic [7:0]  e_wmask [0:NC-1];
  bit          e_wb    [0:NC-1];
  logic [4:0]  e_wbad  [0:NC-1];
  logic [63:0] e_wbdat [0:NC-1];
  bit          e_mis   [0:NC-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Per-cycle comparison against the timeline
  always @(negedge clk) begin
    if (chk_on && cyc < NC) begin
      chk("allowin", 64'(bus.lsu_allowin), 64'(e_allow[cyc]));
      chk("dmem_req", 64'(bus.dmem_req), 64'(e_req[cyc]));
      if (e_req[cyc]) begin
        chk("dmem_we", 64'(bus.dmem_we), 64'(e_we[cyc]));
        chk("dmem_addr", bus.dmem_addr, e_addr[cyc]);
        if (e_we[cyc]) begin
          chk("dmem_wmask", 64'(bus.dmem_wmask), 64'(e_wmask[cyc]));
          chk("dmem_wdata", bus.dmem_wdata, e_wdata[cyc]);
        end
      end
      chk("wb_en", 64'(bus.wb_en), 64'(e_wb[cyc]));
      if (e_wb[cyc]) begin
        chk("wb_addr", 64'(bus.wb_addr), 64'(e_wbad[cyc]));
        chk("wb_data", bus.wb_data, e_wbdat[cyc]);
      end
      chk("misalign", 64'(bus.misalign), 64'(e_mis[cyc]));
    end
  end

  // Reference load result: select the addressed bytes, then extend
  function automatic logic [63:0] m_load(input logic [63:0] rdata, input logic [63:0] addr,
                                         input logic [2:0] f3);
    logic [63:0] v;
    logic [63:0] lim;
    int          nb;
    nb = 1 << f3[1:0];
    v  = rdata >> (8 * (addr % 8));
    if (nb == 8) return v;
    lim = 64'd1 << (8 * nb);
    v   = v % lim;
    if (!f3[2] && v >= (lim >> 1)) v = v - lim;
    return v;
  endfunction

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic set_wb(input int c, input bit en, input logic [4:0] ad, input logic [63:0] d);
    if (c < NC) begin
      e_wb[c]    = en;
      e_wbad[c]  = ad;
      e_wbdat[c] = d;
    end
  endtask

  // Present one instruction now (stage known not to be in MEM), drive the
  // memory response after w wait cycles, and return in the cycle after the
  // instruction leaves MEM (or after capture for non-memory/misaligned).
  task automatic issue(input bit ld, input bit st, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] sd,
                       input logic [4:0] rd, input bit rdw, input int w,
                       input logic [63:0] rdat, input bit stall);
    int k;
    int nb;
    bit mem;
    bit ok;
    k   = cyc;
    mem = ld || st;
    nb  = 1 << f3[1:0];
    ok  = mem && ((a % nb) == 0) && (f3 != 3'b111);
    bus.exu_valid    = 1'b1;
    bus.exu_rd       = a;
    bus.exu_rd_addr  = rd;
    bus.exu_rd_w     = rdw;
    bus.exu_is_load  = ld;
    bus.exu_is_store = st;
    bus.exu_func3    = f3;
    bus.exu_st_data  = sd;
    if (!ok) begin
      set_wb(k + 1, rdw && (rd != 0) && !mem, rd, a);
      if (mem && k + 1 < NC) e_mis[k + 1] = 1'b1;
      step();
      bus.exu_valid = 1'b0;
    end else begin
      for (int c = k + 1; c <= k + 1 + w; c++) begin
        if (c < NC) begin
          e_allow[c] = 1'b0;
          e_req[c]   = 1'b1;
          e_we[c]    = st;
          e_addr[c]  = a - (a % 8);
          e_wmask[c] = 8'(((1 << nb) - 1) << (a % 8));
          e_wdata[c] = sd << (8 * (a % 8));
        end
      end
      set_wb(k + 2 + w, ld && rdw && (rd != 0), rd, m_load(rdat, a, f3));
      step();
      for (int i = 0; i < w; i++) begin
        bus.exu_valid   = stall;
        bus.exu_rd      = {$urandom, $urandom};
        bus.exu_rd_addr = 5'($urandom);
        bus.exu_is_load = 1'($urandom);
        bus.dmem_rdata  = {$urandom, $urandom};
        step();
      end
      bus.exu_valid  = stall;
      bus.dmem_ack   = 1'b1;
      bus.dmem_rdata = rdat;
      step();
      bus.dmem_ack   = 1'b0;
      bus.dmem_rdata = {$urandom, $urandom};
      bus.exu_valid  = 1'b0;
    end
  endtask

  // Idle cycles with stray acks that must be ignored
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.exu_valid  = 1'b0;
      bus.dmem_ack   = 1'($urandom);
      bus.dmem_rdata = {$urandom, $urandom};
      step();
    end
    bus.dmem_ack = 1'b0;
  endtask

  bit          r_ld;
  bit          r_st;
  logic [2:0]  r_f3;
  logic [63:0] r_a;
  int          r_kind;

  initial begin
    n_err  = 0;
    n_chk  = 0;
    chk_on = 1'b0;
    cyc    = 0;
    for (int i = 0; i < NC; i++) begin
      e_allow[i] = 1'b1;
      e_req[i]   = 1'b0;
      e_we[i]    = 1'b0;
      e_addr[i]  = '0;
      e_wdata[i] = '0;
      e_wmask[i] = '0;
      e_wb[i]    = 1'b0;
      e_wbad[i]  = '0;
      e_wbdat[i] = '0;
      e_mis[i]   = 1'b0;
    end
    rst_n            = 1'b0;
    bus.exu_valid    = 1'b0;
    bus.exu_rd       = '0;
    bus.exu_rd_addr  = '0;
    bus.exu_rd_w     = 1'b0;
    bus.exu_is_load  = 1'b0;
    bus.exu_is_store = 1'b0;
    bus.exu_func3    = '0;
    bus.exu_st_data  = '0;
    bus.dmem_ack     = 1'b0;
    bus.dmem_rdata   = '0;

    // reset state
    repeat (3) step();
    chk("rst_allowin", 64'(bus.lsu_allowin), 64'd1);
    chk("rst_req", 64'(bus.dmem_req), 64'd0);
    chk("rst_wb_en", 64'(bus.wb_en), 64'd0);
    chk("rst_wb_data", bus.wb_data, 64'd0);
    chk("rst_misalign", 64'(bus.misalign), 64'd0);
    rst_n = 1'b1;
    step();
    chk_on = 1'b1;

    // ALU back-to-back, last one to x0
    issue(0, 0, 3'd0, 64'h11, 64'd0, 5'd5, 1, 0, 64'd0, 0);
    issue(0, 0, 3'd0, 64'h22, 64'd0, 5'd6, 1, 0, 64'd0, 0);
    issue(0, 0, 3'd0, 64'h33, 64'd0, 5'd0, 1, 0, 64'd0, 0);
    idle(2);
    // LB sign extension with two wait cycles
    issue(1, 0, 3'b000, 64'h1003, 64'd0, 5'd7, 1, 2, 64'h0000_0000_8000_0000, 0);
    idle(2);
    // SH lane placement
    issue(0, 1, 3'b001, 64'h2006, 64'hABCD, 5'd9, 1, 1, 64'd0, 1);
    idle(1);
    // misaligned LW
    issue(1, 0, 3'b010, 64'h3002, 64'd0, 5'd10, 1, 0, 64'd0, 0);
    idle(1);
    // LD captured in the WB cycle of an ALU result, zero-wait memory
    issue(0, 0, 3'd0, 64'h44, 64'd0, 5'd11, 1, 0, 64'd0, 0);
    issue(1, 0, 3'b011, 64'h4008, 64'd0, 5'd12, 1, 0, 64'h0123_4567_89AB_CDEF, 0);
    idle(2);

    // randomized mix
    for (int n = 0; n < 300; n++) begin
      r_kind = $urandom_range(0, 9);
      r_ld   = (r_kind >= 4) && (r_kind <= 6);
      r_st   = (r_kind >= 7);
      r_f3   = r_st ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      r_a    = {32'h0, $urandom};
      if ($urandom_range(0, 3) != 0) r_a = r_a & ~((64'd1 << r_f3[1:0]) - 64'd1);
      issue(r_ld, r_st, r_f3, r_a, {$urandom, $urandom}, 5'($urandom), 1'($urandom),
            $urandom_range(0, 3), {$urandom, $urandom}, 1'($urandom));
      idle($urandom_range(0, 2));
    end
    idle(4);
    chk_on = 1'b0;

    // reset while a load waits for its ack
    bus.exu_valid    = 1'b1;
    bus.exu_rd       = 64'h5000;
    bus.exu_rd_addr  = 5'd13;
    bus.exu_rd_w     = 1'b1;
    bus.exu_is_load  = 1'b1;
    bus.exu_is_store = 1'b0;
    bus.exu_func3    = 3'b011;
    step();
    bus.exu_valid = 1'b0;
    step();
    chk("pre_rst_req", 64'(bus.dmem_req), 64'd1);
    chk("pre_rst_allowin", 64'(bus.lsu_allowin), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 64'(bus.dmem_req), 64'd0);
    chk("mid_rst_allowin", 64'(bus.lsu_allowin), 64'd1);
    chk("mid_rst_wb_en", 64'(bus.wb_en), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    step();
    bus.dmem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_ack_wb_en", 64'(bus.wb_en), 64'd0);
      chk("late_ack_req", 64'(bus.dmem_req), 64'd0);
      chk("late_ack_allowin", 64'(bus.lsu_allowin), 64'd1);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_wb_stage.md
Name: lsu_wb_stage

Overview:
- Pipeline stage 4: the consumer end of the execute-stage result interface (valid, rd value, rd address, rd write enable; allowin returned upstream).
- Captures one execute result per handshake and performs the load/store on a req/ack data-memory port.
- Sign/zero-extends load data, then drives the register-file write port and a forwarding tap back to the execute stage.

Parameters:
- XLEN, 64, datapath and address width (only 64 supported)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- exu_valid  in  1  execute stage presents a result
- exu_rd  in  XLEN  ALU result; effective address when is_load/is_store
- exu_rd_addr  in  5  destination register
- exu_rd_w  in  1  instruction writes rd
- exu_is_load  in  1  load instruction
- exu_is_store  in  1  store instruction
- exu_func3  in  3  RV64 load/store width/sign code
- exu_st_data  in  XLEN  store data (rs2)
- lsu_allowin  out  1  stage can accept; execute advances only when exu_valid && lsu_allowin
- dmem_req  out  1  memory request
- dmem_we  out  1  1=store
- dmem_addr  out  XLEN  8-byte-aligned address (low 3 bits zero)
- dmem_wdata  out  XLEN  lane-shifted store data
- dmem_wmask  out  8  byte enables
- dmem_ack  in  1  request completed (load data valid this cycle)
- dmem_rdata  in  XLEN  aligned 64-bit read data
- wb_en  out  1  register-file write
- wb_addr  out  5  write address
- wb_data  out  XLEN  write data
- misalign  out  1  one-cycle pulse: misaligned access dropped

Behaviour:
- States: IDLE, MEM, WB. Reset (async, rst_n=0): state IDLE; all outputs 0 except lsu_allowin=1; the held instruction is discarded. A pending bus request is dropped immediately (dmem_req=0).
- lsu_allowin = (state != MEM), combinational.
- Capture on clk edge when exu_valid && lsu_allowin: latch all exu_* fields and compute the alignment check.
- Next state on capture:
  - MEM if (is_load|is_store) and aligned;
  - else WB, including misaligned accesses, which set misalign=1 in that WB cycle.
- With no capture, WB→IDLE.
- Alignment: func3[1:0] gives size 1/2/4/8 bytes; aligned iff addr mod size == 0.
- MEM:
  - dmem_req=1 and stable (addr/we/wdata/wmask) until the dmem_ack cycle, inclusive.
  - Requests are issued only in MEM; a store issues no writeback.
  - dmem_addr = {addr[63:3],3'b0}.
  - dmem_wmask = sizemask << addr[2:0], with sizemask 01/03/0F/FF.
  - dmem_wdata = st_data << (8*addr[2:0]).
  - On ack: register the extended load result; next state WB; dmem_req deasserts the following cycle.
- Load extension: rdata >> (8*addr[2:0]), then by func3:
  - 000 sext8, 001 sext16, 010 sext32, 011 full 64;
  - 100 zext8, 101 zext16, 110 zext32;
  - 111 treated as misaligned (dropped, misalign pulse).
- WB (one cycle per instruction): wb_en = rd_w && rd_addr!=0 && !store && !misalign. wb_data is the load result or the latched ALU result.
- Throughput and latency:
  - Non-memory instructions: capture→wb_en is 1 cycle; back-to-back at 1/cycle (WB→WB).
  - Memory instructions: wb_en occurs 1 cycle after ack; lsu_allowin=0 throughout MEM.
- Simultaneous events:
  - Capture in the WB cycle is allowed; the current writeback completes in that same cycle.
  - dmem_ack outside MEM is ignored.
  - dmem_ack in the first MEM cycle is legal (zero-wait memory gives capture→wb_en = 2 cycles).
- Forwarding: the execute stage's bypass consumes wb_en/wb_addr/wb_data directly; no separate tap port.

Decomposition:
- Shared package:
  - func3 load/store encodings (LB..LWU, SB..SD);
  - state encoding localparams (IDLE/MEM/WB);
  - XLEN.
- One natural sub-module: lsu_align. Purely combinational; performs store lane shift/mask, load shift/extend and the misalign check. Reusable by a future cache.

Test Plan:
- ALU back-to-back: 3 results (rd 5/6/0, values 0x11/0x22/0x33, exu_rd_w=1) on consecutive cycles → wb_en high cycles 1,2 with addr 5/6 and data 0x11/0x22; x0 result gives wb_en=0; lsu_allowin stays 1.
- LB sign: addr 0x1003, func3 000, rdata 0x00000000_80000000 with ack after 2 wait cycles → dmem_addr 0x1000; allowin low 3 cycles; wb_data 0xFFFFFFFF_FFFFFF80 one cycle after ack.
- SH lanes: addr 0x2006, st_data 0xABCD → dmem_we=1, wmask 0xC0, wdata 0xABCD0000_00000000; no wb_en.
- Misaligned LW at 0x3002 → no dmem_req, misalign pulse 1 cycle, wb_en=0, allowin never drops.
- Reset mid-MEM: rst_n low while dmem_req=1 awaiting ack → dmem_req=0 immediately; after release state IDLE, allowin=1; a late ack causes no writeback.
- Capture in WB: LD issued while the previous ALU result is in WB → ALU wb_en occurs in the capture cycle; LD proceeds to MEM; zero-wait ack gives wb_en 2 cycles after capture.
